pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline control unit driving the 2-bit ctrl input of every inter-stage pipeline latch (IF/ID, ID/EX, EX/MM, MM/WB, ...).
- Tracks in-flight destination registers in a shift-register scoreboard.
- Detects RAW hazards against the instruction in decode.
- Arbitrates stall, flush and freeze per stage; keeps saturating performance counters.
- Replaces fixed, reset-only ctrl registers with real hazard handling for any pipeline depth.

---
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze controller for every inter-stage latch, with a RAW-hazard scoreboard and saturating counters.
// Optional macro FWD_EN: a forwarding network exists, so only a load-use on the EX entry stalls.
module pipe_hazard_ctrl #(
    parameter int NSTAGE    = 4,
    parameter int REGW      = 4,
    parameter int CNTW      = 16,
    parameter int ZERO_SKIP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REGW-1:0]       id_src_x,
    input  logic                  id_src_x_en,
    input  logic [REGW-1:0]       id_src_y,
    input  logic                  id_src_y_en,
    input  logic [REGW-1:0]       id_dst,
    input  logic                  id_dst_wr,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic [2*NSTAGE-1:0]   ctrl,
    output logic                  pc_hold,
    output logic [CNTW-1:0]       stall_cnt,
    output logic [CNTW-1:0]       flush_cnt
);

    // Only entries that can ever match are stored: the writeback entry is never compared
    // (register file writes through), and with forwarding only the EX entry matters.
`ifdef FWD_EN
    localparam int SBD = 1;
`else
    localparam int SBD = NSTAGE - 2;
`endif

    logic [SBD-1:0]           sb_vld_q, sb_vld_d;
    logic [SBD-1:0][REGW-1:0] sb_dst_q, sb_dst_d;
    logic [SBD-1:0]           sb_wr_q, sb_wr_d;
`ifdef FWD_EN
    logic                     sb_ld_q, sb_ld_d;
`endif
    logic [CNTW-1:0]          stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0]          flush_cnt_q, flush_cnt_d;
    logic                     hazard_s;
    logic                     stall_s;
    logic                     flush_s;

    function automatic logic src_hit(
        input logic [REGW-1:0] src,
        input logic            src_en,
        input logic            e_vld,
        input logic            e_wr,
        input logic [REGW-1:0] e_dst
    );
        logic zero_s;
        zero_s = (ZERO_SKIP != 0) && (src == {REGW{1'b0}});
        return e_vld & e_wr & src_en & (src == e_dst) & ~zero_s;
    endfunction

    // RAW hazard of the decode instruction against the in-flight scoreboard entries
    always_comb begin
        hazard_s = 1'b0;
        for (int k = 0; k < SBD; k++) begin
            hazard_s = hazard_s
                     | src_hit(id_src_x, id_src_x_en, sb_vld_q[k], sb_wr_q[k], sb_dst_q[k])
                     | src_hit(id_src_y, id_src_y_en, sb_vld_q[k], sb_wr_q[k], sb_dst_q[k]);
        end
`ifdef FWD_EN
        hazard_s = hazard_s & sb_ld_q;
`endif
        hazard_s = hazard_s & id_valid;
    end

    // Priority arbitration of per-latch control and PC hold
    always_comb begin
        flush_s = ~rst & ~mem_busy & ex_branch_taken;
        stall_s = ~rst & ~mem_busy & ~ex_branch_taken & hazard_s;
        ctrl    = {NSTAGE{2'b00}};
        pc_hold = 1'b0;
        if (rst) begin
            ctrl    = {NSTAGE{2'b10}};
            pc_hold = 1'b1;
        end else if (mem_busy) begin
            ctrl    = {NSTAGE{2'b01}};
            pc_hold = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl[3:0] = 4'b1010;
            pc_hold   = 1'b0;
        end else if (hazard_s) begin
            ctrl[3:0] = 4'b1001;
            pc_hold   = 1'b1;
        end else begin
            ctrl    = {NSTAGE{2'b00}};
            pc_hold = 1'b0;
        end
    end

    // Scoreboard shift and saturating counter next-state; everything holds during a freeze
    always_comb begin
        sb_vld_d    = sb_vld_q;
        sb_dst_d    = sb_dst_q;
        sb_wr_d     = sb_wr_q;
`ifdef FWD_EN
        sb_ld_d     = sb_ld_q;
`endif
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!mem_busy) begin
            for (int k = 1; k < SBD; k++) begin
                sb_vld_d[k] = sb_vld_q[k-1];
                sb_dst_d[k] = sb_dst_q[k-1];
                sb_wr_d[k]  = sb_wr_q[k-1];
            end
            sb_vld_d[0] = id_valid & ~hazard_s & ~ex_branch_taken;
            sb_dst_d[0] = id_dst;
            sb_wr_d[0]  = id_dst_wr;
`ifdef FWD_EN
            sb_ld_d     = id_is_load;
`endif
        end else begin
            sb_vld_d = sb_vld_q;
        end
        if (stall_s && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_s && (flush_cnt_q != {CNTW{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_vld_q    <= {SBD{1'b0}};
            sb_dst_q    <= {(SBD*REGW){1'b0}};
            sb_wr_q     <= {SBD{1'b0}};
`ifdef FWD_EN
            sb_ld_q     <= 1'b0;
`endif
            stall_cnt_q <= {CNTW{1'b0}};
            flush_cnt_q <= {CNTW{1'b0}};
        end else begin
            sb_vld_q    <= sb_vld_d;
            sb_dst_q    <= sb_dst_d;
            sb_wr_q     <= sb_wr_d;
`ifdef FWD_EN
            sb_ld_q     <= sb_ld_d;
`endif
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver pushes hand-computed expectations, a negedge monitor compares.
module tb_pipe_hazard_ctrl;
    localparam int NSTAGE = 4;
    localparam int REGW   = 4;
`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [7:0] c;
        logic       ph;
        int         sc;
        int         fc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            id_valid = 1'b0;
    logic [REGW-1:0] id_src_x = 4'd0;
    logic            id_src_x_en = 1'b0;
    logic [REGW-1:0] id_src_y = 4'd0;
    logic            id_src_y_en = 1'b0;
    logic [REGW-1:0] id_dst = 4'd0;
    logic            id_dst_wr = 1'b0;
    logic            id_is_load = 1'b0;
    logic            ex_branch_taken = 1'b0;
    logic            mem_busy = 1'b0;
    logic [7:0]      ctrl, ctrl_sat;
    logic            pc_hold, pc_hold_sat;
    logic [15:0]     stall_cnt, flush_cnt;
    logic [3:0]      stall_cnt_sat, flush_cnt_sat;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   sc = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NSTAGE(NSTAGE), .REGW(REGW), .CNTW(16), .ZERO_SKIP(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src_x(id_src_x), .id_src_x_en(id_src_x_en),
        .id_src_y(id_src_y), .id_src_y_en(id_src_y_en),
        .id_dst(id_dst), .id_dst_wr(id_dst_wr), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .ctrl(ctrl), .pc_hold(pc_hold), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.NSTAGE(NSTAGE), .REGW(REGW), .CNTW(4), .ZERO_SKIP(1)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src_x(id_src_x), .id_src_x_en(id_src_x_en),
        .id_src_y(id_src_y), .id_src_y_en(id_src_y_en),
        .id_dst(id_dst), .id_dst_wr(id_dst_wr), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .ctrl(ctrl_sat), .pc_hold(pc_hold_sat), .stall_cnt(stall_cnt_sat), .flush_cnt(flush_cnt_sat)
    );

    function automatic int pick(input int no_fwd, input int fwd);
        return FWD ? fwd : no_fwd;
    endfunction

    function automatic logic [31:0] sat4(input int v);
        return (v > 15) ? 32'd15 : v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic vec(input logic r, input logic v,
                       input logic [3:0] sx, input logic sxe,
                       input logic [3:0] sy, input logic sye,
                       input logic [3:0] d, input logic dw, input logic ld,
                       input logic br, input logic busy,
                       input logic [7:0] ec, input logic eph, input int esc, input int efc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v;
        id_src_x = sx; id_src_x_en = sxe; id_src_y = sy; id_src_y_en = sye;
        id_dst = d; id_dst_wr = dw; id_is_load = ld;
        ex_branch_taken = br; mem_busy = busy;
        e.c = ec; e.ph = eph; e.sc = esc; e.fc = efc;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input int esc, input int efc);
        for (int i = 0; i < n; i++) vec(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, esc, efc);
    endtask

    // Monitor: every cycle the DUT presents a control word; compare it against the oldest expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("ctrl", {24'd0, ctrl}, {24'd0, mon_e.c});
            chk("pc_hold", {31'd0, pc_hold}, {31'd0, mon_e.ph});
            chk("stall_cnt", {16'd0, stall_cnt}, mon_e.sc);
            chk("flush_cnt", {16'd0, flush_cnt}, mon_e.fc);
            chk("sat_ctrl", {24'd0, ctrl_sat}, {24'd0, mon_e.c});
            chk("sat_stall_cnt", {28'd0, stall_cnt_sat}, sat4(mon_e.sc));
            chk("sat_flush_cnt", {28'd0, flush_cnt_sat}, sat4(mon_e.fc));
        end
    end

    initial begin
        // reset held two cycles, then idle
        vec(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 0, 0);
        vec(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 0, 0);
        idle(1, 0, 0);

        // load r3 then consumer of r3
        vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09, 1'b1, 0, 0);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0,
            FWD ? 8'h00 : 8'h09, !FWD, 1, 0);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, pick(2, 1), 0);
        idle(3, pick(2, 1), 0);

        // ALU producer r5 then consumer on source Y
        vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, pick(2, 1), 0);
        vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0,
            FWD ? 8'h00 : 8'h09, !FWD, pick(2, 1), 0);
        vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0,
            FWD ? 8'h00 : 8'h09, !FWD, pick(3, 1), 0);
        vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, pick(4, 1), 0);
        idle(3, pick(4, 1), 0);

        // taken branch while a load-use hazard is present; flushed r8 must not enter the scoreboard
        vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, pick(4, 1), 0);
        vec(1'b0, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0A, 1'b0, pick(4, 1), 0);
        vec(1'b0, 1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, pick(4, 1), 1);
        idle(3, pick(4, 1), 1);

        // freeze for 3 cycles during a load-use stall
        vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, pick(4, 1), 1);
        for (int i = 0; i < 3; i++)
            vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, pick(4, 1), 1);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09, 1'b1, pick(4, 1), 1);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0,
            FWD ? 8'h00 : 8'h09, !FWD, pick(5, 2), 1);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, pick(6, 2), 1);
        idle(3, pick(6, 2), 1);

        // reset in the middle of a stall discards everything
        vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, pick(6, 2), 1);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09, 1'b1, pick(6, 2), 1);
        vec(1'b1, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, pick(7, 3), 1);
        vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
        idle(3, 0, 0);

        // register 0 never creates a hazard
        vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
        vec(1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0);
        idle(3, 0, 0);

        // 20 stall cycles: 16-bit counter reaches 20, 4-bit counter sticks at 15
        sc = 0;
        for (int i = 0; i < pick(10, 20); i++) begin
            vec(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, sc, 0);
            for (int j = 0; j < pick(2, 1); j++) begin
                vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h09, 1'b1, sc, 0);
                sc++;
            end
            vec(1'b0, 1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, sc, 0);
        end
        idle(1, 20, 0);

        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
